instr_sequencer: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit CPU core. It fetches instructions from ROM, decodes opcode[15:12] / dest[11:6] / src[5:0], reads operands from RAM, drives the ALU and writes the result back. Every memory access uses a valid/ready handshake. It replaces the fixed 4-state fetch FSM with one controller that owns pc, IR and every ROM/RAM/ALU control strobe.

---
 rtl/instr_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_instr_sequencer.sv | 477 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// Multi-cycle instruction sequencer: fetches from ROM, reads operands from RAM,
// drives the ALU and writes results back, all over valid/ready handshakes.
module instr_sequencer #(
  parameter logic [7:0]  PC_RESET = 8'h00,
  parameter int unsigned RAM_AW   = 6,
  parameter int unsigned DATA_W   = 16
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_run,
  output logic [7:0]          o_rom_address,
  output logic                o_rom_read_enable,
  input  logic [15:0]         i_rom_data,
  input  logic                i_rom_valid,
  output logic                o_ir_load,
  output logic                o_ram_read,
  output logic [RAM_AW-1:0]   o_ram_read_addr,
  input  logic [DATA_W-1:0]   i_ram_rdata,
  input  logic                i_ram_rvalid,
  output logic                o_ram_write,
  output logic [RAM_AW-1:0]   o_ram_write_addr,
  output logic [DATA_W-1:0]   o_ram_data_out,
  input  logic                i_ram_wready,
  output logic [3:0]          o_alu_op,
  output logic [DATA_W-1:0]   o_alu_a,
  output logic [DATA_W-1:0]   o_alu_b,
  input  logic [2*DATA_W-1:0] i_alu_result,
  output logic [7:0]          o_pc,
  output logic [2:0]          o_state,
  output logic                o_zero_flag,
  output logic                o_halted,
  output logic                o_illegal
);

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StRdSrc  = 3'd3,
    StRdDst  = 3'd4,
    StExec   = 3'd5,
    StWb     = 3'd6,
    StHalt   = 3'd7
  } state_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpMov  = 4'hA;
  localparam logic [3:0] OpJmp  = 4'hB;
  localparam logic [3:0] OpJz   = 4'hC;
  localparam logic [3:0] OpHalt = 4'hF;

  state_e              r_state;
  logic [7:0]          r_pc;
  logic [15:0]         r_ir;
  logic [DATA_W-1:0]   r_opa;
  logic [DATA_W-1:0]   r_opb;
  logic [DATA_W-1:0]   r_res;
  logic                r_zero;

  state_e              w_state_next;
  logic [7:0]          w_pc_next;
  logic [15:0]         w_ir_next;
  logic [DATA_W-1:0]   w_opa_next;
  logic [DATA_W-1:0]   w_opb_next;
  logic [DATA_W-1:0]   w_res_next;
  logic                w_zero_next;

  logic [3:0]          w_opcode;
  logic [RAM_AW-1:0]   w_dest;
  logic [RAM_AW-1:0]   w_src;
  logic [7:0]          w_target;
  logic                w_is_mov;
  state_e              w_eoi_state;
  logic [DATA_W-1:0]   w_alu_low;
  logic                w_unused_alu_high;

  assign w_opcode    = r_ir[15:12];
  assign w_dest      = r_ir[6 +: RAM_AW];
  assign w_src       = r_ir[0 +: RAM_AW];
  assign w_target    = r_ir[7:0];
  assign w_is_mov    = (w_opcode == OpMov);
  assign w_alu_low   = i_alu_result[DATA_W-1:0];
  // run is only consulted here and in IDLE, so mid-instruction changes are inert.
  assign w_eoi_state = i_run ? StFetch : StIdle;

  assign w_unused_alu_high = ^i_alu_result[2*DATA_W-1:DATA_W];

  always_comb begin
    w_state_next      = r_state;
    w_pc_next         = r_pc;
    w_ir_next         = r_ir;
    w_opa_next        = r_opa;
    w_opb_next        = r_opb;
    w_res_next        = r_res;
    w_zero_next       = r_zero;

    o_rom_address     = 8'h00;
    o_rom_read_enable = 1'b0;
    o_ir_load         = 1'b0;
    o_ram_read        = 1'b0;
    o_ram_read_addr   = '0;
    o_ram_write       = 1'b0;
    o_ram_write_addr  = '0;
    o_ram_data_out    = '0;
    o_alu_op          = 4'h0;
    o_alu_a           = '0;
    o_alu_b           = '0;
    o_halted          = 1'b0;
    o_illegal         = 1'b0;

    case (r_state)
      StIdle: begin
        if (i_run) begin
          w_state_next = StFetch;
        end
      end

      StFetch: begin
        o_rom_read_enable = 1'b1;
        o_rom_address     = r_pc;
        if (i_rom_valid) begin
          o_ir_load    = 1'b1;
          w_ir_next    = i_rom_data;
          w_pc_next    = r_pc + 8'd1;
          w_state_next = StDecode;
        end
      end

      StDecode: begin
        case (w_opcode)
          OpNop: begin
            w_state_next = w_eoi_state;
          end
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8, 4'h9, OpMov: begin
            w_state_next = StRdSrc;
          end
          OpJmp: begin
            w_pc_next    = w_target;
            w_state_next = w_eoi_state;
          end
          OpJz: begin
            if (r_zero) begin
              w_pc_next = w_target;
            end
            w_state_next = w_eoi_state;
          end
          OpHalt: begin
            w_state_next = StHalt;
          end
          default: begin
            o_illegal    = 1'b1;
            w_state_next = w_eoi_state;
          end
        endcase
      end

      StRdSrc: begin
        o_ram_read      = 1'b1;
        o_ram_read_addr = w_src;
        if (i_ram_rvalid) begin
          w_opb_next   = i_ram_rdata;
          w_state_next = w_is_mov ? StWb : StRdDst;
        end
      end

      StRdDst: begin
        o_ram_read      = 1'b1;
        o_ram_read_addr = w_dest;
        if (i_ram_rvalid) begin
          w_opa_next   = i_ram_rdata;
          w_state_next = StExec;
        end
      end

      StExec: begin
        o_alu_op     = w_opcode;
        o_alu_a      = r_opa;
        o_alu_b      = r_opb;
        w_res_next   = w_alu_low;
        w_zero_next  = (w_alu_low == '0);
        w_state_next = StWb;
      end

      StWb: begin
        o_ram_write      = 1'b1;
        o_ram_write_addr = w_dest;
        o_ram_data_out   = w_is_mov ? r_opb : r_res;
        if (i_ram_wready) begin
          w_state_next = w_eoi_state;
        end
      end

      StHalt: begin
        o_halted = 1'b1;
      end

      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      r_state <= StIdle;
      r_pc    <= PC_RESET;
      r_ir    <= 16'h0000;
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_ir    <= w_ir_next;
      r_opa   <= w_opa_next;
      r_opb   <= w_opb_next;
      r_res   <= w_res_next;
      r_zero  <= w_zero_next;
    end
  end

  assign o_pc        = r_pc;
  assign o_state     = r_state;
  assign o_zero_flag = r_zero;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboarded bench for instr_sequencer: behavioural ROM/RAM/ALU with
// configurable wait states and an instruction-level reference model.
module tb_instr_sequencer;

  logic        clk;
  logic        reset;
  logic        run;
  logic [7:0]  rom_address;
  logic        rom_read_enable;
  logic [15:0] rom_data;
  logic        rom_valid;
  logic        ir_load;
  logic        ram_read;
  logic [5:0]  ram_read_addr;
  logic [15:0] ram_rdata;
  logic        ram_rvalid;
  logic        ram_write;
  logic [5:0]  ram_write_addr;
  logic [15:0] ram_data_out;
  logic        ram_wready;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic [31:0] alu_result;
  logic [7:0]  pc;
  logic [2:0]  state;
  logic        zero_flag;
  logic        halted;
  logic        illegal;

  instr_sequencer #(
    .PC_RESET (8'h00),
    .RAM_AW   (6),
    .DATA_W   (16)
  ) dut (
    .i_clk             (clk),
    .i_reset           (reset),
    .i_run             (run),
    .o_rom_address     (rom_address),
    .o_rom_read_enable (rom_read_enable),
    .i_rom_data        (rom_data),
    .i_rom_valid       (rom_valid),
    .o_ir_load         (ir_load),
    .o_ram_read        (ram_read),
    .o_ram_read_addr   (ram_read_addr),
    .i_ram_rdata       (ram_rdata),
    .i_ram_rvalid      (ram_rvalid),
    .o_ram_write       (ram_write),
    .o_ram_write_addr  (ram_write_addr),
    .o_ram_data_out    (ram_data_out),
    .i_ram_wready      (ram_wready),
    .o_alu_op          (alu_op),
    .o_alu_a           (alu_a),
    .o_alu_b           (alu_b),
    .i_alu_result      (alu_result),
    .o_pc              (pc),
    .o_state           (state),
    .o_zero_flag       (zero_flag),
    .o_halted          (halted),
    .o_illegal         (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] alu_f(input logic [3:0] op, input logic [15:0] a,
                                        input logic [15:0] b);
    case (op)
      4'h1:    alu_f = {16'h0, a} + {16'h0, b};
      4'h2:    alu_f = {16'h0, a - b};
      4'h3:    alu_f = {16'h0, a & b};
      4'h4:    alu_f = {16'h0, a | b};
      4'h5:    alu_f = {16'h0, a ^ b};
      4'h6:    alu_f = {16'h0, a} * {16'h0, b};
      default: alu_f = {16'h0, a + b};
    endcase
  endfunction

  assign alu_result = alu_f(alu_op, alu_a, alu_b);

  logic [15:0] rom   [256];
  logic [15:0] ram   [64];
  logic [15:0] m_ram [64];

  int  rom_wait, rd_wait, wr_wait;
  bit  wready_always;
  int  rom_cnt, rd_cnt, wr_cnt;
  int  cyc, last_fetch;
  int  obs_illegal, m_illegal;
  logic [7:0] m_pc;
  bit  m_zero, m_halt;
  int  n_checks, n_pass;

  int          fetch_q [$];
  logic [5:0]  rd_q    [$];
  logic [21:0] wr_q    [$];
  logic [35:0] alu_q   [$];
  int          lat_q   [$];

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
  endtask

  // Executes up to max_n instructions at ISA level, queueing expected bus traffic.
  task automatic model_run(input int max_n);
    int n;
    int ww;
    logic [15:0] ir;
    logic [3:0]  op;
    logic [5:0]  d, s;
    logic [31:0] r;
    n  = 0;
    ww = wready_always ? 0 : wr_wait;
    while (!m_halt && n < max_n) begin
      ir = rom[m_pc];
      fetch_q.push_back(int'(m_pc));
      m_pc = m_pc + 8'd1;
      n++;
      op = ir[15:12];
      d  = ir[11:6];
      s  = ir[5:0];
      if (op >= 4'h1 && op <= 4'h9) begin
        rd_q.push_back(s);
        rd_q.push_back(d);
        alu_q.push_back({op, m_ram[d], m_ram[s]});
        r = alu_f(op, m_ram[d], m_ram[s]);
        m_zero = (r[15:0] == 16'h0);
        wr_q.push_back({d, r[15:0]});
        m_ram[d] = r[15:0];
        lat_q.push_back(6 + rom_wait + 2 * rd_wait + ww);
      end else if (op == 4'hA) begin
        rd_q.push_back(s);
        wr_q.push_back({d, m_ram[s]});
        m_ram[d] = m_ram[s];
        lat_q.push_back(4 + rom_wait + rd_wait + ww);
      end else if (op == 4'hF) begin
        m_halt = 1'b1;
      end else begin
        if (op == 4'hB) m_pc = ir[7:0];
        else if (op == 4'hC && m_zero) m_pc = ir[7:0];
        else if (op == 4'hD || op == 4'hE) m_illegal++;
        lat_q.push_back(2 + rom_wait);
      end
    end
  endtask

  task automatic flush_queues();
    fetch_q.delete();
    rd_q.delete();
    wr_q.delete();
    alu_q.delete();
    lat_q.delete();
  endtask

  task automatic do_reset();
    run = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic sync_model();
    m_pc = 8'h00;
    m_zero = 1'b0;
    m_halt = 1'b0;
    m_illegal = 0;
    obs_illegal = 0;
    for (int i = 0; i < 64; i++) m_ram[i] = ram[i];
    flush_queues();
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    for (int i = 0; i < 64; i++) ram[i] = 16'h0100 + 16'(i);
  endtask

  task automatic run_until_halt(input int budget, input string tag);
    int n;
    n = 0;
    run = 1'b1;
    while (!halted && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_halt_reached"}, halted, 1);
    check({tag, "_fetch_left"}, fetch_q.size(), 0);
    check({tag, "_rd_left"}, rd_q.size(), 0);
    check({tag, "_wr_left"}, wr_q.size(), 0);
    check({tag, "_alu_left"}, alu_q.size(), 0);
    check({tag, "_pc"}, pc, m_pc);
    check({tag, "_zero"}, zero_flag, m_zero);
    check({tag, "_illegal_cnt"}, obs_illegal, m_illegal);
  endtask

  // Memory responders: valid/ready after a programmable number of request cycles.
  initial begin
    rom_valid = 1'b0;
    rom_data = 16'hDEAD;
    ram_rvalid = 1'b0;
    ram_rdata = 16'hBAD0;
    ram_wready = 1'b0;
    rom_cnt = 0;
    rd_cnt = 0;
    wr_cnt = 0;
    forever begin
      @(posedge clk);
      #1;
      if (rom_read_enable && rom_cnt == rom_wait) begin
        rom_valid = 1'b1;
        rom_data = rom[rom_address];
        rom_cnt = 0;
      end else begin
        rom_valid = 1'b0;
        rom_data = 16'hDEAD;
        rom_cnt = rom_read_enable ? rom_cnt + 1 : 0;
      end
      if (ram_read && rd_cnt == rd_wait) begin
        ram_rvalid = 1'b1;
        ram_rdata = ram[ram_read_addr];
        rd_cnt = 0;
      end else begin
        ram_rvalid = 1'b0;
        ram_rdata = 16'hBAD0;
        rd_cnt = ram_read ? rd_cnt + 1 : 0;
      end
      if (wready_always) begin
        ram_wready = 1'b1;
      end else if (ram_write && wr_cnt == wr_wait) begin
        ram_wready = 1'b1;
        wr_cnt = 0;
      end else begin
        ram_wready = 1'b0;
        wr_cnt = ram_write ? wr_cnt + 1 : 0;
      end
    end
  end

  // Monitor: protocol rules every cycle, scoreboard pops on each handshake.
  initial begin
    logic       p_rst, p_rom_re, p_rom_v, p_rd, p_rv, p_wr, p_wrdy;
    logic [7:0] p_rom_addr;
    logic [5:0] p_rd_addr, p_wr_addr;
    logic [15:0] p_wdata;
    logic [2:0] p_state;
    cyc = 0;
    last_fetch = -1;
    p_rst = 1'b0;
    p_state = 3'd0;
    {p_rom_re, p_rom_v, p_rd, p_rv, p_wr, p_wrdy} = '0;
    p_rom_addr = '0;
    p_rd_addr = '0;
    p_wr_addr = '0;
    p_wdata = '0;
    forever begin
      @(negedge clk);
      cyc++;
      check("rw_excl", ram_read & ram_write, 0);
      check("ir_load", ir_load, rom_read_enable & rom_valid);
      check("gate_addr", {(rom_read_enable ? 8'h00 : rom_address),
                          (ram_read ? 6'h00 : ram_read_addr),
                          (ram_write ? 22'h0 : {ram_write_addr, ram_data_out})}, 0);
      check("gate_alu", (state == 3'd5) ? 36'h0 : {alu_op, alu_a, alu_b}, 0);
      check("halted_flag", halted, state == 3'd7);
      if (state == 3'd7) check("halt_quiet", {rom_read_enable, ram_read, ram_write}, 0);
      if (p_rst && p_rom_re && !p_rom_v)
        check("rom_hold", {rom_read_enable, rom_address}, {1'b1, p_rom_addr});
      if (p_rst && p_rd && !p_rv)
        check("rd_hold", {ram_read, ram_read_addr}, {1'b1, p_rd_addr});
      if (p_rst && p_wr && !p_wrdy)
        check("wr_hold", {ram_write, ram_write_addr, ram_data_out},
              {1'b1, p_wr_addr, p_wdata});
      if (rom_read_enable && rom_valid) begin
        check("fetch_expected", fetch_q.size() > 0, 1);
        if (fetch_q.size() > 0) check("fetch_addr", rom_address, fetch_q.pop_front());
      end
      if (ram_read && ram_rvalid) begin
        check("rd_expected", rd_q.size() > 0, 1);
        if (rd_q.size() > 0) check("rd_addr", ram_read_addr, rd_q.pop_front());
      end
      if (state == 3'd5) begin
        check("alu_expected", alu_q.size() > 0, 1);
        if (alu_q.size() > 0) check("alu_ops", {alu_op, alu_a, alu_b}, alu_q.pop_front());
      end
      if (ram_write && ram_wready) begin
        check("wr_expected", wr_q.size() > 0, 1);
        if (wr_q.size() > 0) check("wr_addr_data", {ram_write_addr, ram_data_out},
                                   wr_q.pop_front());
        ram[ram_write_addr] = ram_data_out;
      end
      if (illegal) obs_illegal++;
      if (state == 3'd1 && p_state != 3'd1) begin
        if (last_fetch >= 0) begin
          check("lat_expected", lat_q.size() > 0, 1);
          if (lat_q.size() > 0) check("instr_latency", cyc - last_fetch, lat_q.pop_front());
        end
        last_fetch = cyc;
      end
      if (state == 3'd0) last_fetch = -1;
      p_rst = reset;
      p_state = state;
      p_rom_re = rom_read_enable;
      p_rom_v = rom_valid;
      p_rom_addr = rom_address;
      p_rd = ram_read;
      p_rv = ram_rvalid;
      p_rd_addr = ram_read_addr;
      p_wr = ram_write;
      p_wrdy = ram_wready;
      p_wr_addr = ram_write_addr;
      p_wdata = ram_data_out;
    end
  end

  task automatic load_prog_a();
    clear_mem();
    rom[0] = 16'h0000;  // NOP
    rom[1] = 16'h1083;  // ADD d2 s3
    rom[2] = 16'h2082;  // SUB d2 s2 -> 0
    rom[3] = 16'hA101;  // MOV d4 s1
    rom[4] = 16'hD000;
    rom[5] = 16'hE123;
    rom[6] = 16'hB008;  // JMP 8
    rom[7] = 16'h1000;
    rom[8] = 16'hF000;
    ram[1] = 16'h1234;
    ram[2] = 16'h0007;
    ram[3] = 16'h0005;
  endtask

  task automatic load_prog_b();
    clear_mem();
    rom[8'h00] = 16'hC0F0;  // JZ F0
    rom[8'h01] = 16'h1001;  // ADD d0 s1
    rom[8'h02] = 16'hC0FE;  // JZ FE
    rom[8'hFE] = 16'hA0C5;  // MOV d3 s5
    rom[8'hFF] = 16'h0000;
    rom[8'hF0] = 16'hF000;
    ram[0] = 16'hFFFF;
    ram[1] = 16'h0001;
    ram[5] = 16'hBEEF;
  endtask

  task automatic load_prog_c();
    clear_mem();
    rom[0] = 16'h1083;
    rom[1] = 16'hF000;
    ram[2] = 16'h0007;
    ram[3] = 16'h0005;
  endtask

  initial begin
    int n;
    int waits [3][3];
    waits = '{'{0, 0, 0}, '{3, 2, 0}, '{1, 0, 3}};
    n_checks = 0;
    n_pass = 0;
    reset = 1'b0;
    run = 1'b0;
    rom_wait = 0;
    rd_wait = 0;
    wr_wait = 0;
    wready_always = 1'b0;
    obs_illegal = 0;
    clear_mem();
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("rst_state", state, 0);
    end
    check("rst_pc", pc, 8'h00);
    check("rst_flags", {zero_flag, halted, illegal}, 0);
    check("rst_strobes", {rom_read_enable, ram_read, ram_write, ir_load}, 0);

    for (int k = 0; k < 3; k++) begin
      rom_wait = waits[k][0];
      rd_wait = waits[k][1];
      wr_wait = waits[k][2];
      do_reset();
      load_prog_a();
      sync_model();
      model_run(100);
      run_until_halt(400, "progA");
      check("progA_ram2", ram[2], 16'h0000);
      check("progA_ram4", ram[4], 16'h1234);
      check("progA_illegal", obs_illegal, 2);
      if (k == 0) begin
        repeat (20) begin
          @(negedge clk);
          check("halt_hold", {state, rom_read_enable, ram_read, ram_write}, {3'd7, 3'b000});
        end
      end
    end

    rom_wait = 1;
    rd_wait = 1;
    wr_wait = 0;
    wready_always = 1'b1;
    do_reset();
    load_prog_b();
    sync_model();
    model_run(100);
    run_until_halt(400, "progB");
    check("progB_ram0", ram[0], 16'h0000);
    check("progB_ram3", ram[3], 16'hBEEF);
    check("progB_zero", zero_flag, 1);
    check("progB_pc", pc, 8'hF1);
    wready_always = 1'b0;

    rom_wait = 0;
    rd_wait = 0;
    wr_wait = 10;
    do_reset();
    load_prog_c();
    sync_model();
    model_run(100);
    run = 1'b1;
    n = 0;
    while (state != 3'd6 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("wb_reached", state, 6);
    @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;
    check("wbrst_write", ram_write, 0);
    check("wbrst_pc", pc, 8'h00);
    check("wbrst_state", state, 0);
    reset = 1'b1;
    run = 1'b0;
    flush_queues();
    check("wbrst_ram2", ram[2], 16'h0007);

    rom_wait = 0;
    rd_wait = 3;
    wr_wait = 0;
    do_reset();
    load_prog_c();
    sync_model();
    model_run(1);
    run = 1'b1;
    n = 0;
    while (state != 3'd4 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rd_dst_reached", state, 4);
    run = 1'b0;
    n = 0;
    while (state != 3'd0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("drop_idle", state, 0);
    check("drop_wr_done", wr_q.size(), 0);
    check("drop_ram2", ram[2], 16'h000C);
    check("drop_pc", pc, 8'h01);
    repeat (3) begin
      @(negedge clk);
      check("drop_stay_idle", state, 0);
    end
    lat_q.delete();
    model_run(100);
    run_until_halt(200, "drop");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
